// File: rtl/cmd_dispatch.sv
// Command FIFO consumer: pops 72-bit words, forwards register writes
// over valid/ready and holds off further pops while a FENCE drains.
module cmd_dispatch #(
    parameter int WIDTH = 72,
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 64,
    parameter logic [ADDR_BITS-1:0] FENCE_ADDR = 7'h7F
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_rd_data,
    output logic                 fifo_rd_en,
    output logic                 reg_wr_valid,
    input  logic                 reg_wr_ready,
    output logic [ADDR_BITS-1:0] reg_wr_addr,
    output logic [DATA_BITS-1:0] reg_wr_data,
    input  logic                 pipe_idle,
    output logic                 fence_active,
    output logic                 busy,
    output logic [15:0]          cmd_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        FENCE_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 rd_en;

    // Reserved top bit of the command word is deliberately dropped.
    logic unused_rsvd;
    assign unused_rsvd = fifo_rd_data[WIDTH-1];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                addr_d  = fifo_rd_data[DATA_BITS +: ADDR_BITS];
                data_d  = fifo_rd_data[DATA_BITS-1:0];
                state_d = (addr_d == FENCE_ADDR) ? FENCE_WAIT : ISSUE;
            end
            ISSUE: begin
                if (reg_wr_ready) begin
                    cnt_d = cnt_q + 16'd1;
                    if (!fifo_empty) begin
                        rd_en   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FENCE_WAIT: begin
                if (pipe_idle) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pop strobe is combinational, so it must be masked while reset is held.
    assign fifo_rd_en   = rd_en && rst_n;
    assign reg_wr_valid = (state_q == ISSUE);
    assign fence_active = (state_q == FENCE_WAIT);
    assign busy         = (state_q != IDLE);
    assign reg_wr_addr  = addr_q;
    assign reg_wr_data  = data_q;
    assign cmd_count    = cnt_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Bench for cmd_dispatch: FIFO model, transaction-level reference model
// checked every cycle, plus directed literal checks.
module tb_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [71:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic        reg_wr_valid;
    logic        reg_wr_ready;
    logic [6:0]  reg_wr_addr;
    logic [63:0] reg_wr_data;
    logic        pipe_idle;
    logic        fence_active;
    logic        busy;
    logic [15:0] cmd_count;

    always #5 clk = ~clk;

    cmd_dispatch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en  (fifo_rd_en),
        .reg_wr_valid(reg_wr_valid),
        .reg_wr_ready(reg_wr_ready),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .pipe_idle   (pipe_idle),
        .fence_active(fence_active),
        .busy        (busy),
        .cmd_count   (cmd_count)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] mk(input logic r, input logic [6:0] a,
                                       input logic [63:0] d);
        return {r, a, d};
    endfunction

    // FIFO model: registered read data, appears the cycle after a pop
    logic [71:0] q[$];
    int          pops = 0;
    logic        pop_pend = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        #1;
        if (pop_pend && q.size() > 0) begin
            fifo_rd_data = q.pop_front();
            pops++;
        end
        fifo_empty = (q.size() == 0);
    end

    // Reference model: what the dispatcher holds this cycle
    logic        m_inf = 0, m_hold = 0, m_fen = 0;
    logic [6:0]  m_addr = '0;
    logic [63:0] m_data = '0;
    logic [15:0] m_count = '0;
    logic [6:0]  acc[$];
    logic        exp_en;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_en = rst_n && !fifo_empty &&
                     ((!m_inf && !m_hold && !m_fen) || (m_hold && reg_wr_ready));
            chk("rd_en", {63'd0, fifo_rd_en}, {63'd0, exp_en});
            chk("valid", {63'd0, reg_wr_valid}, {63'd0, m_hold});
            chk("addr", {57'd0, reg_wr_addr}, {57'd0, m_addr});
            chk("data", reg_wr_data, m_data);
            chk("fence", {63'd0, fence_active}, {63'd0, m_fen});
            chk("busy", {63'd0, busy}, {63'd0, m_inf | m_hold | m_fen});
            chk("count", {48'd0, cmd_count}, {48'd0, m_count});
            if (!rst_n) begin
                m_inf = 0; m_hold = 0; m_fen = 0;
                m_addr = '0; m_data = '0; m_count = '0;
            end else if (m_inf) begin
                m_inf  = 0;
                m_addr = fifo_rd_data[70:64];
                m_data = fifo_rd_data[63:0];
                if (m_addr == 7'h7F) m_fen = 1; else m_hold = 1;
            end else if (m_hold) begin
                if (reg_wr_ready) begin
                    acc.push_back(m_addr);
                    m_count++;
                    m_hold = 0;
                    m_inf  = exp_en;
                end
            end else if (m_fen) begin
                if (pipe_idle) begin
                    m_count++;
                    m_fen = 0;
                end
            end else begin
                m_inf = exp_en;
            end
        end
        pop_pend = fifo_rd_en;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [71:0] w);
        q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            if (reg_wr_valid) break;
            tick();
        end
        chk("wait_valid", {63'd0, reg_wr_valid}, 64'd1);
    endtask

    int n, p0, a0, nf, bad6;
    int vc[$];

    initial begin
        rst_n = 0; reg_wr_ready = 0; pipe_idle = 1;
        fifo_rd_data = '0; fifo_empty = 1;
        push(mk(1'b0, 7'h12, 64'hDEAD_BEEF_0123_4567));
        tick();
        chk_en = 1;
        tick(); tick();
        chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        chk("rst_valid", {63'd0, reg_wr_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_count", {48'd0, cmd_count}, 64'd0);

        // single write
        reg_wr_ready = 1; rst_n = 1;
        #1;
        chk("first_pop", {63'd0, fifo_rd_en}, 64'd1);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (reg_wr_valid) begin
                n = i;
                break;
            end
        end
        chk("latency", 64'(n), 64'd2);
        chk("w1_addr", {57'd0, reg_wr_addr}, 64'h12);
        chk("w1_data", reg_wr_data, 64'hDEAD_BEEF_0123_4567);
        tick();
        chk("w1_count", {48'd0, cmd_count}, 64'd1);
        chk("w1_busy", {63'd0, busy}, 64'd0);

        // backpressure then back-to-back
        reg_wr_ready = 0; p0 = pops; a0 = acc.size();
        push(mk(1'b0, 7'h01, 64'h1111_0000_0000_0001));
        push(mk(1'b1, 7'h02, 64'h2222_0000_0000_0002));
        push(mk(1'b0, 7'h03, 64'h3333_0000_0000_0003));
        #1;
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", {63'd0, reg_wr_valid}, 64'd1);
            chk("stall_addr", {57'd0, reg_wr_addr}, 64'h01);
            chk("stall_data", reg_wr_data, 64'h1111_0000_0000_0001);
            chk("stall_nopop", {63'd0, fifo_rd_en}, 64'd0);
            tick();
        end
        reg_wr_ready = 1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (reg_wr_valid) vc.push_back(k);
            tick();
        end
        chk("b2b_n", 64'(vc.size()), 64'd3);
        if (vc.size() == 3) begin
            chk("b2b_gap1", 64'(vc[1] - vc[0]), 64'd2);
            chk("b2b_gap2", 64'(vc[2] - vc[1]), 64'd2);
        end
        chk("b2b_acc", 64'(acc.size() - a0), 64'd3);
        if (acc.size() == a0 + 3) begin
            chk("b2b_ord0", {57'd0, acc[a0]}, 64'h01);
            chk("b2b_ord1", {57'd0, acc[a0+1]}, 64'h02);
            chk("b2b_ord2", {57'd0, acc[a0+2]}, 64'h03);
        end
        chk("b2b_pops", 64'(pops - p0), 64'd3);
        chk("b2b_count", {48'd0, cmd_count}, 64'd4);

        // fence
        pipe_idle = 0; a0 = acc.size(); nf = 0; bad6 = 0;
        push(mk(1'b0, 7'h05, 64'h5555_5555_5555_5555));
        push(mk(1'b0, 7'h7F, 64'hFFFF_0000_FFFF_0000));
        push(mk(1'b0, 7'h06, 64'h6666_6666_6666_6666));
        for (int k = 0; k < 60; k++) begin
            tick();
            if (nf == 10) pipe_idle = 1;
            #1;
            if (fence_active) nf++;
            if (reg_wr_valid && reg_wr_addr == 7'h06 && !pipe_idle) bad6++;
        end
        chk("fence_cycles", 64'(nf), 64'd11);
        chk("fence_early6", 64'(bad6), 64'd0);
        chk("fence_acc", 64'(acc.size() - a0), 64'd2);
        if (acc.size() == a0 + 2) begin
            chk("fence_w5", {57'd0, acc[a0]}, 64'h05);
            chk("fence_w6", {57'd0, acc[a0+1]}, 64'h06);
        end
        chk("fence_count", {48'd0, cmd_count}, 64'd7);

        // reset during a stalled handshake
        reg_wr_ready = 0; a0 = acc.size();
        push(mk(1'b0, 7'h09, 64'h9999_9999_9999_9999));
        #1;
        wait_valid();
        tick();
        rst_n = 0;
        tick();
        chk("mid_rst_valid", {63'd0, reg_wr_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_count", {48'd0, cmd_count}, 64'd0);
        rst_n = 1; reg_wr_ready = 1;
        repeat (6) tick();
        chk("mid_rst_drop", 64'(acc.size() - a0), 64'd0);

        // counter wrap
        tick();
        force dut.cnt_q = 16'hFFFF;
        m_count = 16'hFFFF;
        tick();
        release dut.cnt_q;
        #1;
        chk("wrap_pre", {48'd0, cmd_count}, 64'hFFFF);
        push(mk(1'b0, 7'h33, 64'h0123_4567_89AB_CDEF));
        #1;
        wait_valid();
        tick();
        chk("wrap_post", {48'd0, cmd_count}, 64'd0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
